assoc_cache: RTL and testbench
==============================

// Module: assoc_cache
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate cache with integrated control FSM.
//  Sits between a CPU/arbiter port (256-bit line interface with byte enables) and physical memory.
//  Generalises the single-way datapath: configurable ways and sets, tree pseudo-LRU replacement,
//  victim writeback sequencing and resettable valid/dirty/LRU state.
// PARAMETERS
//  WAYS       4  ways per set; power of two, 1..8 (WAYS=1 -> direct-mapped, no LRU state)
//  S_INDEX    3  set-index bits; SETS = 2**S_INDEX
//  Derived: OFFSET=5 (32-byte line), TAG_W = 32-S_INDEX-OFFSET
// PORTS
//  clk              in   1    clock, all state on rising edge
//  rst_n            in   1    asynchronous active-low reset
//  mem_read         in   1    CPU read request; held until mem_resp
//  mem_write        in   1    CPU write request; held until mem_resp
//  mem_address      in   32   CPU byte address; bits [4:0] ignored
//  mem_byte_enable  in   32   per-byte write mask for mem_wdata
//  mem_wdata        in   256  CPU write line
//  mem_rdata        out  256  line of hit way; valid when mem_resp=1
//  mem_resp         out  1    one-cycle completion pulse
//  pmem_read        out  1    physical memory line read; held until pmem_resp
//  pmem_write       out  1    physical memory line write; held until pmem_resp
//  pmem_address     out  32   line-aligned physical address ([4:0]=0)
//  pmem_wdata       out  256  victim line for writeback
//  pmem_rdata       in   256  fill line
//  pmem_resp        in   1    physical memory completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; all valid, dirty, LRU bits=0; mem_resp, pmem_read, pmem_write=0;
//   pmem_address=0. Data/tag arrays not reset (gated by valid).
//  FSM: IDLE -> CHECK -> {IDLE | WRITEBACK | FILL}; WRITEBACK -> FILL -> CHECK.
//  IDLE: on mem_read|mem_write latch address/req type -> CHECK. Both high: treated as write.
//  CHECK: hit = any way valid && tag match (at most one; multi-hit is an assertion failure).
//   Hit read: mem_resp=1, mem_rdata=hit line, LRU updated -> IDLE.
//   Hit write: bytes with mem_byte_enable=1 replaced, dirty=1, mem_resp=1, LRU updated -> IDLE.
//   Miss: victim = lowest-index invalid way, else pLRU victim; latch victim index.
//    victim valid&dirty -> WRITEBACK, else -> FILL. No mem_resp on miss.
//  WRITEBACK: pmem_write=1, pmem_address={victim tag,index,5'b0}, pmem_wdata=victim line;
//   on pmem_resp -> FILL. Victim state untouched until fill.
//  FILL: pmem_read=1, pmem_address={req tag,index,5'b0}; on pmem_resp write pmem_rdata,
//   tag, valid=1, dirty=0 into victim way -> CHECK (guaranteed hit; write hit merges then).
//  Latency: hit = mem_resp 2nd cycle after request asserted; clean miss = hit + fill + 1 cycle.
//  pLRU: binary tree, WAYS-1 bits/set; on every hit, bits on path point away from accessed way.
//   Victim walks tree following bits. Fill does not update; the following CHECK hit does.
//  pmem_read and pmem_write never both high; outputs registered or decoded from state only.
//  mem_address/type changes while request pending: illegal (assertion), internal latch used.
//  pmem_resp outside WRITEBACK/FILL ignored. Reset mid-transaction: pmem_read/write drop
//   immediately (async), no mem_resp, all lines invalid.
//  Index wrap: S_INDEX bits of address only; aliasing lines contend by tag.
// STRUCTURE
//  cache_pkg: state enum {IDLE,CHECK,WRITEBACK,FILL}, LINE_W=256, OFFSET=5,
//   address field extract functions (tag/index) parameterised by S_INDEX.
//  Sub-module cache_plru #(WAYS): per-set tree bits in, accessed way in -> next bits;
//   bits in -> victim way out (pure combinational, instanced once on the addressed set).
//  Arrays: flop-based per way/set (data with byte write-enable, tag, valid, dirty).
// TESTING
//  1 Reset, read 0x0000_0040 -> miss, pmem_read addr 0x40, return line A -> mem_rdata=A, no pmem_write.
//  2 Write BE=0x0000_000F data 0xFF.. to 0x40 -> hit, mem_resp 2nd cycle; reread low 4 bytes=0xFF, rest=A.
//  3 WAYS=4,S_INDEX=3: fill 5 lines to set 2 (stride 0x100); 5th evicts pLRU way; dirty victim
//    -> pmem_write at victim address precedes pmem_read, pmem_wdata=victim line.
//  4 Touch ways 0,1,2,3 in order then miss -> victim way 0; re-touch 0 then miss -> victim way 2 (tree).
//  5 Assert rst_n=0 during FILL with pmem_read high -> pmem_read low same cycle, later read to same
//    address misses again.
//  6 WAYS=1: two addresses 0x000/0x100 alternate reads -> every access misses, clean victims, no writes.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache.
//   cache_state_e : controller states
//   LINE_W, OFFSET, BYTES : line geometry (32-byte lines)
//   addr_index / addr_tag : field extraction for a given number of set-index bits
package cache_pkg;

    localparam int unsigned LINE_W = 256;
    localparam int unsigned OFFSET = 5;
    localparam int unsigned BYTES  = LINE_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWriteback,
        StFill
    } cache_state_e;

    // Results are 32 bits wide; callers size-cast to S_INDEX / TAG_W.
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int unsigned s_index);
        return (addr >> OFFSET) & ((32'd1 << s_index) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int unsigned s_index);
        return addr >> (OFFSET + s_index);
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set (purely combinational).
//   bits       : current tree bits of the set (node 0 = root, children 2n+1 / 2n+2)
//   access_way : way being hit
//   next_bits  : tree bits after the access (path points away from access_way)
//   victim     : way reached by following the current bits (0 = left, 1 = right)
module cache_plru #(
    parameter int unsigned WAYS = 4,
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1,
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [PLRU_W-1:0] bits,
    input  logic [WAY_W-1:0]  access_way,
    output logic [PLRU_W-1:0] next_bits,
    output logic [WAY_W-1:0]  victim
);

    localparam int LEVELS = $clog2(WAYS);

    always_comb begin
        int  node;
        logic dir;
        next_bits = bits;
        victim    = '0;
        dir       = 1'b0;

        // Update: walk the accessed way's path from the MSB, flipping each node away.
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
            dir = access_way[LEVELS-1-l];
            for (int n = 0; n < int'(PLRU_W); n++) begin
                if (n == node) next_bits[n] = ~dir;
            end
            node = 2 * node + 1 + int'(dir);
        end

        // Victim: follow the stored bits down the tree.
        node = 0;
        for (int l = 0; l < LEVELS; l++) begin
            dir = 1'b0;
            for (int n = 0; n < int'(PLRU_W); n++) begin
                if (n == node) dir = bits[n];
            end
            victim[LEVELS-1-l] = dir;
            node = 2 * node + 1 + int'(dir);
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back / write-allocate cache with its control FSM.
//   CPU side : mem_read/mem_write/mem_address/mem_byte_enable/mem_wdata in,
//              mem_rdata/mem_resp out (resp is a one-cycle pulse in CHECK on a hit)
//   Memory   : pmem_read/pmem_write/pmem_address/pmem_wdata out,
//              pmem_rdata/pmem_resp in
// Misses always end with a fill followed by a second CHECK, which is then a hit; write
// misses merge their bytes in that CHECK.
module assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned WAYS    = 4,
    parameter int unsigned S_INDEX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_byte_enable,
    input  logic [255:0]      mem_wdata,
    output logic [255:0]      mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [255:0]      pmem_wdata,
    input  logic [255:0]      pmem_rdata,
    input  logic              pmem_resp
);

    localparam int unsigned SETS   = 1 << S_INDEX;
    localparam int unsigned TAG_W  = 32 - S_INDEX - OFFSET;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    cache_state_e     state_q;
    logic [31:0]      addr_q;
    logic             write_q;
    logic [WAY_W-1:0] victim_q;

    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [PLRU_W-1:0] lru_q   [SETS];

    logic [S_INDEX-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [WAYS-1:0]    hit_vec;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_sel;
    logic [WAY_W-1:0]   plru_victim;
    logic [PLRU_W-1:0]  lru_next;
    logic               inv_found;

    assign idx     = S_INDEX'(addr_index(addr_q, S_INDEX));
    assign req_tag = TAG_W'(addr_tag(addr_q, S_INDEX));

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == req_tag)) begin
                hit_vec[w] = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
        hit = |hit_vec;
    end

    // Empty ways are filled lowest-first; pLRU only picks among a full set.
    always_comb begin
        inv_found  = 1'b0;
        victim_sel = plru_victim;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (!inv_found && !valid_q[idx][w]) begin
                victim_sel = WAY_W'(w);
                inv_found  = 1'b1;
            end
        end
    end

    cache_plru #(
        .WAYS(WAYS)
    ) u_plru (
        .bits       (lru_q[idx]),
        .access_way (hit_way),
        .next_bits  (lru_next),
        .victim     (plru_victim)
    );

    // Controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            write_q  <= 1'b0;
            victim_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_read || mem_write) begin
                        addr_q  <= mem_address;
                        write_q <= mem_write;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (hit) begin
                        state_q <= StIdle;
                    end else begin
                        victim_q <= victim_sel;
                        state_q  <= (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel])
                                    ? StWriteback : StFill;
                    end
                end
                StWriteback: if (pmem_resp) state_q <= StFill;
                StFill:      if (pmem_resp) state_q <= StCheck;
                default:     state_q <= StIdle;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid gates them.
    always_ff @(posedge clk) begin
        if (state_q == StCheck && hit && write_q) begin
            for (int b = 0; b < int'(BYTES); b++) begin
                if (mem_byte_enable[b]) data_q[hit_way][idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end else if (state_q == StFill && pmem_resp) begin
            data_q[victim_q][idx] <= pmem_rdata;
            tag_q[victim_q][idx]  <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SETS); s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                lru_q[s]   <= '0;
            end
        end else begin
            if (state_q == StCheck && hit) begin
                lru_q[idx] <= lru_next;
                if (write_q) dirty_q[idx][hit_way] <= 1'b1;
            end
            if (state_q == StFill && pmem_resp) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

    assign mem_resp   = (state_q == StCheck) && hit;
    assign mem_rdata  = data_q[hit_way][idx];
    assign pmem_read  = (state_q == StFill);
    assign pmem_write = (state_q == StWriteback);
    assign pmem_wdata = data_q[victim_q][idx];

    always_comb begin
        case (state_q)
            StWriteback: pmem_address = {tag_q[victim_q][idx], idx, {OFFSET{1'b0}}};
            StFill:      pmem_address = {req_tag, idx, {OFFSET{1'b0}}};
            default:     pmem_address = '0;
        endcase
    end

    a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StCheck) |-> $onehot0(hit_vec));

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != StIdle && (mem_read || mem_write)) |->
        (mem_address[31:OFFSET] == addr_q[31:OFFSET] && mem_write == write_q));

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench: 4-way/8-set instance (a) and direct-mapped instance (b),
// each with a fixed-latency memory responder that logs every pmem transaction.
module tb_assoc_cache;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance a: WAYS=4, S_INDEX=3
    logic         mem_read_a, mem_write_a, mem_resp_a;
    logic [31:0]  mem_address_a, be_a;
    logic [255:0] wdata_a, rdata_a;
    logic         pmem_read_a, pmem_write_a, pmem_resp_a;
    logic [31:0]  pmem_address_a;
    logic [255:0] pmem_wdata_a, pmem_rdata_a;

    // Instance b: WAYS=1, S_INDEX=3
    logic         mem_read_b, mem_write_b, mem_resp_b;
    logic [31:0]  mem_address_b, be_b;
    logic [255:0] wdata_b, rdata_b;
    logic         pmem_read_b, pmem_write_b, pmem_resp_b;
    logic [31:0]  pmem_address_b;
    logic [255:0] pmem_wdata_b, pmem_rdata_b;

    assoc_cache #(.WAYS(4), .S_INDEX(3)) u_dut_a (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read_a),
        .mem_write       (mem_write_a),
        .mem_address     (mem_address_a),
        .mem_byte_enable (be_a),
        .mem_wdata       (wdata_a),
        .mem_rdata       (rdata_a),
        .mem_resp        (mem_resp_a),
        .pmem_read       (pmem_read_a),
        .pmem_write      (pmem_write_a),
        .pmem_address    (pmem_address_a),
        .pmem_wdata      (pmem_wdata_a),
        .pmem_rdata      (pmem_rdata_a),
        .pmem_resp       (pmem_resp_a)
    );

    assoc_cache #(.WAYS(1), .S_INDEX(3)) u_dut_b (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read_b),
        .mem_write       (mem_write_b),
        .mem_address     (mem_address_b),
        .mem_byte_enable (be_b),
        .mem_wdata       (wdata_b),
        .mem_rdata       (rdata_b),
        .mem_resp        (mem_resp_b),
        .pmem_read       (pmem_read_b),
        .pmem_write      (pmem_write_b),
        .pmem_address    (pmem_address_b),
        .pmem_wdata      (pmem_wdata_b),
        .pmem_rdata      (pmem_rdata_b),
        .pmem_resp       (pmem_resp_b)
    );

    typedef struct {
        int           d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } ev_t;

    ev_t          ev_q[$];
    logic [255:0] mem_m [logic [31:0]];
    logic         both_high = 1'b0;
    int           n_checks  = 0;
    int           n_fail    = 0;

    task automatic check_value(input string tag, input logic [255:0] got,
                               input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = a ^ (32'h5A00_0000 + k * 32'h0101_0101);
        return l;
    endfunction

    function automatic logic [255:0] mem_get(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return line_pat(a);
    endfunction

    // Responds three cycles after a request appears; pmem_resp is a one-cycle pulse.
    task automatic responder(input int d);
        int           wait_cnt;
        logic         rd, wr;
        logic [31:0]  pa;
        logic [255:0] pw;
        wait_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (d == 0) begin
                rd = pmem_read_a; wr = pmem_write_a; pa = pmem_address_a; pw = pmem_wdata_a;
                pmem_resp_a = 1'b0;
            end else begin
                rd = pmem_read_b; wr = pmem_write_b; pa = pmem_address_b; pw = pmem_wdata_b;
                pmem_resp_b = 1'b0;
            end
            if (rd && wr) both_high = 1'b1;
            if (rst_n && (rd || wr)) begin
                if (wait_cnt == 2) begin
                    wait_cnt = 0;
                    ev_q.push_back('{d, wr, pa, wr ? pw : mem_get(pa)});
                    if (wr) mem_m[pa] = pw;
                    if (d == 0) begin
                        pmem_rdata_a = mem_get(pa);
                        pmem_resp_a  = 1'b1;
                    end else begin
                        pmem_rdata_b = mem_get(pa);
                        pmem_resp_b  = 1'b1;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    endtask

    initial responder(0);
    initial responder(1);

    task automatic set_req(input int d, input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] be, input logic [255:0] wd);
        if (d == 0) begin
            mem_read_a = rd; mem_write_a = wr; mem_address_a = a; be_a = be; wdata_a = wd;
        end else begin
            mem_read_b = rd; mem_write_b = wr; mem_address_b = a; be_b = be; wdata_b = wd;
        end
    endtask

    // cyc counts falling edges from request assertion up to and including mem_resp.
    task automatic access(input int d, input logic wr, input logic [31:0] a,
                          input logic [31:0] be, input logic [255:0] wd,
                          output logic [255:0] rd, output int cyc);
        logic got;
        @(posedge clk);
        #2;
        set_req(d, !wr, wr, a, be, wd);
        cyc = 0;
        got = 1'b0;
        rd  = '0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if ((d == 0) ? mem_resp_a : mem_resp_b) begin
                got = 1'b1;
                rd  = (d == 0) ? rdata_a : rdata_b;
            end
        end
        check_value("resp_seen", 256'(got), 256'(1));
        @(posedge clk);
        #2;
        set_req(d, 1'b0, 1'b0, a, '0, '0);
    endtask

    task automatic check_ev(input string tag, input int idx, input logic wr,
                            input logic [31:0] a, input logic [255:0] data);
        if (ev_q.size() > idx) begin
            check_value({tag, "_type"}, 256'(ev_q[idx].wr), 256'(wr));
            check_value({tag, "_addr"}, 256'(ev_q[idx].addr), 256'(a));
            check_value({tag, "_data"}, ev_q[idx].data, data);
        end
    endtask

    initial begin
        logic [255:0] rd, exp_line, mod40;
        int           cyc, n;

        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        pmem_resp_a = 1'b0; pmem_rdata_a = '0;
        pmem_resp_b = 1'b0; pmem_rdata_b = '0;
        repeat (3) @(negedge clk);
        check_value("rst_mem_resp", 256'(mem_resp_a), 256'(0));
        check_value("rst_pmem_read", 256'(pmem_read_a), 256'(0));
        check_value("rst_pmem_write", 256'(pmem_write_a), 256'(0));
        check_value("rst_pmem_addr", 256'(pmem_address_a), 256'(0));
        rst_n = 1'b1;

        // 1: cold read miss
        ev_q.delete();
        access(0, 1'b0, 32'h40, '0, '0, rd, cyc);
        check_value("t1_rdata", rd, line_pat(32'h40));
        check_value("t1_cycles", 256'(cyc), 256'(6));
        check_value("t1_nev", 256'(ev_q.size()), 256'(1));
        check_ev("t1_ev0", 0, 1'b0, 32'h40, line_pat(32'h40));

        // 2: write hit low word, reread
        mod40 = line_pat(32'h40);
        mod40[31:0] = 32'hFFFF_FFFF;
        ev_q.delete();
        access(0, 1'b1, 32'h40, 32'h0000_000F, {256{1'b1}}, rd, cyc);
        check_value("t2_wr_cycles", 256'(cyc), 256'(2));
        access(0, 1'b0, 32'h40, '0, '0, rd, cyc);
        check_value("t2_rd_cycles", 256'(cyc), 256'(2));
        check_value("t2_rdata", rd, mod40);
        check_value("t2_nev", 256'(ev_q.size()), 256'(0));

        // Write miss allocates then merges the top word
        exp_line = line_pat(32'h80);
        exp_line[255:224] = 32'hABAB_ABAB;
        access(0, 1'b1, 32'h80, 32'hF000_0000, {32{8'hAB}}, rd, cyc);
        check_value("wm_cycles", 256'(cyc), 256'(6));
        access(0, 1'b0, 32'h80, '0, '0, rd, cyc);
        check_value("wm_rdata", rd, exp_line);
        check_value("wm_rd_cycles", 256'(cyc), 256'(2));

        // 3/4: fill set 2, touch 0..3, then miss evicts dirty way 0
        for (int i = 1; i < 4; i++) begin
            access(0, 1'b0, 32'h40 + i * 32'h100, '0, '0, rd, cyc);
            check_value("t3_fill_rdata", rd, line_pat(32'h40 + i * 32'h100));
            check_value("t3_fill_cycles", 256'(cyc), 256'(6));
        end
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b0, 32'h40 + i * 32'h100, '0, '0, rd, cyc);
            check_value("t4_touch_cycles", 256'(cyc), 256'(2));
        end
        ev_q.delete();
        access(0, 1'b0, 32'h440, '0, '0, rd, cyc);
        check_value("t3_evict_rdata", rd, line_pat(32'h440));
        check_value("t3_evict_cycles", 256'(cyc), 256'(9));
        check_value("t3_evict_nev", 256'(ev_q.size()), 256'(2));
        check_ev("t3_wb", 0, 1'b1, 32'h40, mod40);
        check_ev("t3_fill", 1, 1'b0, 32'h440, line_pat(32'h440));

        // Re-touch way 0, then the tree selects way 2 (0x240)
        access(0, 1'b0, 32'h440, '0, '0, rd, cyc);
        check_value("t4_retouch_cycles", 256'(cyc), 256'(2));
        ev_q.delete();
        access(0, 1'b0, 32'h540, '0, '0, rd, cyc);
        check_value("t4_miss_cycles", 256'(cyc), 256'(6));
        check_value("t4_miss_nev", 256'(ev_q.size()), 256'(1));
        check_ev("t4_fill", 0, 1'b0, 32'h540, line_pat(32'h540));
        access(0, 1'b0, 32'h140, '0, '0, rd, cyc);
        check_value("t4_keep140", 256'(cyc), 256'(2));
        access(0, 1'b0, 32'h340, '0, '0, rd, cyc);
        check_value("t4_keep340", 256'(cyc), 256'(2));
        access(0, 1'b0, 32'h440, '0, '0, rd, cyc);
        check_value("t4_keep440", 256'(cyc), 256'(2));
        access(0, 1'b0, 32'h240, '0, '0, rd, cyc);
        check_value("t4_gone240", 256'(cyc), 256'(6));

        // 5: reset while filling
        @(posedge clk);
        #2;
        set_req(0, 1'b1, 1'b0, 32'h600, '0, '0);
        n = 0;
        while (!pmem_read_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value("t5_fill_seen", 256'(pmem_read_a), 256'(1));
        rst_n = 1'b0;
        #1;
        check_value("t5_pmem_read_drop", 256'(pmem_read_a), 256'(0));
        check_value("t5_no_resp", 256'(mem_resp_a), 256'(0));
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ev_q.delete();
        access(0, 1'b0, 32'h600, '0, '0, rd, cyc);
        check_value("t5_remiss_cycles", 256'(cyc), 256'(6));
        check_value("t5_remiss_rdata", rd, line_pat(32'h600));
        // Written-back data survived in memory; the cache itself was cleared
        access(0, 1'b0, 32'h40, '0, '0, rd, cyc);
        check_value("t5_40_cycles", 256'(cyc), 256'(6));
        check_value("t5_40_rdata", rd, mod40);
        check_value("t5_nev", 256'(ev_q.size()), 256'(2));

        // 6: direct-mapped thrash
        ev_q.delete();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = (i % 2 == 0) ? 32'h000 : 32'h100;
            access(1, 1'b0, a, '0, '0, rd, cyc);
            check_value("t6_cycles", 256'(cyc), 256'(6));
            check_value("t6_rdata", rd, line_pat(a));
            check_ev("t6_ev", i, 1'b0, a, line_pat(a));
        end
        check_value("t6_nev", 256'(ev_q.size()), 256'(4));

        check_value("pmem_rw_exclusive", 256'(both_high), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
